pwm_scan: RTL and testbench



---
 rtl/pwm_scan.sv | 84 ++++++++
 tb/tb_pwm_scan.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pwm_scan.sv
// Per-channel PWM generator fed from a 12-bit duty memory with a registered-address read port.
// Duties are scanned into shadow registers every period and committed together at the wrap.
module pwm_scan #(
  parameter  int WIDTH   = 12,
  parameter  int ENTRIES = 6,
  localparam int AW      = $clog2(ENTRIES)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  output logic [AW-1:0]      o_mem_addr,
  input  logic [WIDTH-1:0]   i_mem_data,
  output logic [ENTRIES-1:0] o_pwm_out,
  output logic               o_period_start
);

  localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ENTRIES_W = WIDTH'(ENTRIES);

  logic [WIDTH-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_shadow [ENTRIES];
  logic [WIDTH-1:0]   r_active [ENTRIES];
  logic [ENTRIES-1:0] r_pwm;
  logic               r_period_start;
  logic               w_wrap;

  assign w_wrap = i_enable && (r_cnt == CNT_MAX);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (!i_enable) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Address leads capture by one cycle to cover the memory's registered read.
  assign o_mem_addr = (r_cnt < ENTRIES_W) ? r_cnt[AW-1:0] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_chan
      localparam logic [WIDTH-1:0] CAP_CNT = WIDTH'(gi + 1);

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_shadow[gi] <= '0;
        end else if (i_enable && (r_cnt == CAP_CNT)) begin
          r_shadow[gi] <= i_mem_data;
        end
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_active[gi] <= '0;
        end else if (w_wrap) begin
          r_active[gi] <= r_shadow[gi];
        end
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_pwm[gi] <= 1'b0;
        end else begin
          r_pwm[gi] <= i_enable && (r_cnt < r_active[gi]);
        end
      end
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_period_start <= 1'b0;
    end else begin
      r_period_start <= i_enable && (r_cnt == '0);
    end
  end

  assign o_pwm_out      = r_pwm;
  assign o_period_start = r_period_start;

endmodule

// File: tb/tb_pwm_scan.sv
// Directed bench for pwm_scan at WIDTH=4, ENTRIES=6 with a registered-read duty memory model.
// Outputs are sampled on the falling edge; each measured period is one transaction line.
module tb_pwm_scan;
  localparam int W = 4;
  localparam int N = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [2:0]   mem_addr;
  logic [W-1:0] mem_data;
  logic [N-1:0] pwm;
  logic         ps;
  logic [W-1:0] mem [N];

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [2:0] exp_addr [16] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd0,
                                3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};

  // Duty sets, channel 5 in the top nibble down to channel 0 in the bottom.
  localparam logic [23:0] DUTY_ZERO  = 24'h000000;
  localparam logic [23:0] DUTY_BASIC = {4'd3, 4'd15, 4'd8, 4'd5, 4'd1, 4'd0};
  localparam logic [23:0] DUTY_UPD   = {4'd3, 4'd15, 4'd8, 4'd12, 4'd1, 4'd0};
  localparam logic [23:0] DUTY_NEW   = {4'd14, 4'd1, 4'd11, 4'd6, 4'd4, 4'd2};

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= mem[mem_addr];

  pwm_scan #(.WIDTH(W), .ENTRIES(N)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_enable       (enable),
    .o_mem_addr     (mem_addr),
    .i_mem_data     (mem_data),
    .o_pwm_out      (pwm),
    .o_period_start (ps)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_mem(input logic [23:0] duties);
    for (int i = 0; i < N; i++) mem[i] = duties[i*4 +: 4];
  endtask

  // Waits (bounded) for period_start, then records 16 samples per channel.
  task automatic measure(input string tag, input logic [23:0] duties);
    logic [15:0] hist [N];
    int n;
    n = 0;
    while (ps !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, " period_start"}, 32'(ps), 32'd1);
    for (int j = 0; j < 16; j++) begin
      if (j > 0) @(negedge clk);
      for (int i = 0; i < N; i++) hist[i][j] = pwm[i];
    end
    for (int i = 0; i < N; i++)
      check($sformatf("%s ch%0d", tag, i), 32'(hist[i]),
            32'((16'h1 << duties[i*4 +: 4]) - 16'h1));
    $display("period %s: ch0..5 high-run masks %h %h %h %h %h %h",
             tag, hist[0], hist[1], hist[2], hist[3], hist[4], hist[5]);
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    load_mem(DUTY_BASIC);

    repeat (2) @(negedge clk);
    check("reset pwm", 32'(pwm), 32'd0);
    check("reset period_start", 32'(ps), 32'd0);
    check("reset mem_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle pwm", 32'(pwm), 32'd0);
    check("idle period_start", 32'(ps), 32'd0);
    check("idle mem_addr", 32'(mem_addr), 32'd0);
    $display("reset and idle state sampled");

    // First period: address sweep, outputs still zero.
    enable = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      @(negedge clk);
      check($sformatf("sweep addr t=%0d", t), 32'(mem_addr), 32'(exp_addr[t % 16]));
      check($sformatf("sweep ps t=%0d", t), 32'(ps), 32'(t == 1));
      check($sformatf("sweep pwm t=%0d", t), 32'(pwm), 32'd0);
    end
    $display("address sweep sampled");

    measure("basic p2", DUTY_BASIC);

    // Write lands after channel 2's capture slot of this period.
    repeat (9) @(negedge clk);
    mem[2] = 4'd12;
    $display("wrote ch2=12 at cnt=9");
    measure("upd N+1", DUTY_BASIC);
    measure("upd N+2", DUTY_UPD);

    load_mem(DUTY_NEW);
    repeat (7) @(negedge clk);
    check("pre-drop pwm", 32'(pwm), 32'h1C);
    enable = 1'b0;
    @(negedge clk);
    check("drop pwm", 32'(pwm), 32'd0);
    check("drop period_start", 32'(ps), 32'd0);
    check("drop mem_addr", 32'(mem_addr), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("disabled pwm %0d", k), 32'(pwm), 32'd0);
      check($sformatf("disabled ps %0d", k), 32'(ps), 32'd0);
    end
    $display("enable dropped at cnt=7");

    enable = 1'b1;
    @(negedge clk);
    check("reenable ps", 32'(ps), 32'd1);
    check("reenable mem_addr", 32'(mem_addr), 32'd1);
    measure("reen p1", DUTY_UPD);
    measure("reen p2", DUTY_NEW);

    repeat (10) @(negedge clk);
    check("pre-reset pwm", 32'(pwm), 32'h28);
    rst = 1'b1;
    #1;
    check("async reset pwm", 32'(pwm), 32'd0);
    check("async reset period_start", 32'(ps), 32'd0);
    check("async reset mem_addr", 32'(mem_addr), 32'd0);
    $display("async reset asserted at cnt=10");
    @(negedge clk);
    rst = 1'b0;
    measure("post-reset p1", DUTY_ZERO);
    measure("post-reset p2", DUTY_NEW);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
